// File: rtl/ysyx_23060136_ifu_bht_pkg.sv
// Shared types and constants for the IFU branch history table.
package ysyx_23060136_ifu_bht_pkg;

  localparam int unsigned ysyx_23060136_BITS_W = 32;

  typedef enum logic [1:0] {
    BHT_CTR_SNT = 2'b00,
    BHT_CTR_WNT = 2'b01,
    BHT_CTR_WT  = 2'b10,
    BHT_CTR_ST  = 2'b11
  } bht_ctr_e;

  // The tag field is full word width so any TAG_W fits; unused upper bits stay zero.
  typedef struct packed {
    logic                            valid;
    logic [ysyx_23060136_BITS_W-1:0] tag;
    bht_ctr_e                        ctr;
    logic [ysyx_23060136_BITS_W-1:0] target;
  } bht_entry_t;

endpackage

// File: rtl/ysyx_23060136_ifu_bht_if.sv
// Lookup, training and perf-counter signals between IFU/EXU2 and the BHT.
interface ysyx_23060136_ifu_bht_if;
  import ysyx_23060136_ifu_bht_pkg::*;

  logic [ysyx_23060136_BITS_W-1:0] IFU_pc;
  logic                            IFU_pre_take;
  logic [ysyx_23060136_BITS_W-1:0] IFU_pre_target;
  logic [ysyx_23060136_BITS_W-1:0] BHT_pc;
  logic                            BHT_pre_true;
  logic                            BHT_pre_false;
  logic                            BHT_taken;
  logic [ysyx_23060136_BITS_W-1:0] BHT_target;
  logic                            BHT_flush;
  logic [ysyx_23060136_BITS_W-1:0] BHT_correct_cnt;
  logic [ysyx_23060136_BITS_W-1:0] BHT_wrong_cnt;

  modport slave (
    input  IFU_pc, BHT_pc, BHT_pre_true, BHT_pre_false, BHT_taken, BHT_target, BHT_flush,
    output IFU_pre_take, IFU_pre_target, BHT_correct_cnt, BHT_wrong_cnt
  );

  modport master (
    output IFU_pc, BHT_pc, BHT_pre_true, BHT_pre_false, BHT_taken, BHT_target, BHT_flush,
    input  IFU_pre_take, IFU_pre_target, BHT_correct_cnt, BHT_wrong_cnt
  );
endinterface

// File: rtl/ysyx_23060136_ifu_bht_ctr.sv
// 2-bit saturating branch counter next-state function.
module ysyx_23060136_IFU_BHT_CTR
  import ysyx_23060136_ifu_bht_pkg::*;
(
  input  bht_ctr_e ctr,
  input  logic     taken,
  output bht_ctr_e ctr_nxt
);

  always_comb begin
    ctr_nxt = ctr;
    case (ctr)
      BHT_CTR_SNT: ctr_nxt = taken ? BHT_CTR_WNT : BHT_CTR_SNT;
      BHT_CTR_WNT: ctr_nxt = taken ? BHT_CTR_WT  : BHT_CTR_SNT;
      BHT_CTR_WT:  ctr_nxt = taken ? BHT_CTR_ST  : BHT_CTR_WNT;
      BHT_CTR_ST:  ctr_nxt = taken ? BHT_CTR_ST  : BHT_CTR_WT;
      default:     ctr_nxt = ctr;
    endcase
  end

endmodule

// File: rtl/ysyx_23060136_ifu_bht.sv
// Branch history table + target buffer: combinational fetch-time lookup, EXU2-trained.
module ysyx_23060136_ifu_bht
  import ysyx_23060136_ifu_bht_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned TAG_W       = 8
)(
  input logic                     clk,
  input logic                     rst,
  ysyx_23060136_ifu_bht_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  bht_entry_t bht_q [BHT_ENTRIES];

  logic [IDX_W-1:0]                ifu_idx, upd_idx;
  logic [ysyx_23060136_BITS_W-1:0] ifu_tag, upd_tag;
  bht_entry_t                      ifu_ent, upd_ent;
  logic                            ifu_hit, upd_hit, upd;
  logic [1:0]                      ifu_ctr_bits;
  bht_ctr_e                        upd_ctr_nxt;
  logic [ysyx_23060136_BITS_W-1:0] correct_q, wrong_q;
  logic                            unused_pc;

  assign ifu_idx = bus.IFU_pc[IDX_W+1:2];
  assign upd_idx = bus.BHT_pc[IDX_W+1:2];
  assign ifu_tag = ysyx_23060136_BITS_W'(bus.IFU_pc[IDX_W+2 +: TAG_W]);
  assign upd_tag = ysyx_23060136_BITS_W'(bus.BHT_pc[IDX_W+2 +: TAG_W]);
  assign unused_pc = ^{bus.IFU_pc, bus.BHT_pc};

  assign ifu_ent      = bht_q[ifu_idx];
  assign ifu_ctr_bits = ifu_ent.ctr;
  assign ifu_hit      = ifu_ent.valid && (ifu_ent.tag == ifu_tag);

  assign bus.IFU_pre_take   = ifu_hit && ifu_ctr_bits[1];
  assign bus.IFU_pre_target = bus.IFU_pre_take ? ifu_ent.target : bus.IFU_pc + 32'd4;

  assign upd     = bus.BHT_pre_true | bus.BHT_pre_false;
  assign upd_ent = bht_q[upd_idx];
  assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

  ysyx_23060136_IFU_BHT_CTR u_ctr (
    .ctr     (upd_ent.ctr),
    .taken   (bus.BHT_taken),
    .ctr_nxt (upd_ctr_nxt)
  );

  // Flush is applied after the update in the same block so its valid clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++)
        bht_q[i] <= '{valid: 1'b0, tag: '0, ctr: BHT_CTR_WNT, target: '0};
      correct_q <= '0;
      wrong_q   <= '0;
    end else begin
      if (upd) begin
        if (upd_hit) begin
          bht_q[upd_idx].ctr <= upd_ctr_nxt;
          if (bus.BHT_taken)
            bht_q[upd_idx].target <= bus.BHT_target;
        end else if (bus.BHT_taken) begin
          bht_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag, ctr: BHT_CTR_WT, target: bus.BHT_target};
        end
      end
      if (bus.BHT_flush) begin
        for (int unsigned i = 0; i < BHT_ENTRIES; i++)
          bht_q[i].valid <= 1'b0;
      end
      if (bus.BHT_pre_true)
        correct_q <= correct_q + 32'd1;
      if (bus.BHT_pre_false)
        wrong_q <= wrong_q + 32'd1;
    end
  end

  assign bus.BHT_correct_cnt = correct_q;
  assign bus.BHT_wrong_cnt   = wrong_q;

endmodule

// File: tb/tb_ysyx_23060136_ifu_bht.sv
// Directed self-checking bench for ysyx_23060136_ifu_bht.
module tb_ysyx_23060136_ifu_bht;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_ok = '0;
  logic [31:0] exp_bad = '0;

  ysyx_23060136_ifu_bht_if bus ();

  ysyx_23060136_ifu_bht #(.BHT_ENTRIES(16), .TAG_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!rst) assert (!(bus.BHT_pre_true && bus.BHT_pre_false))
      else $error("pre_true and pre_false both high");

  // One training pulse; caller sits 1 time unit after a rising edge.
  task automatic pulse(input logic [31:0] pc, input logic ok, input logic tk, input logic [31:0] tgt);
    bus.BHT_pc = pc; bus.BHT_pre_true = ok; bus.BHT_pre_false = !ok;
    bus.BHT_taken = tk; bus.BHT_target = tgt;
    @(posedge clk); #1;
    bus.BHT_pre_true = 1'b0; bus.BHT_pre_false = 1'b0;
    if (ok) exp_ok++; else exp_bad++;
  endtask

  task automatic test_reset;
    bus.IFU_pc = 32'h8000_0010; #1;
    checks++; if (bus.IFU_pre_take !== 1'b0) begin failures++; $display("FAIL reset_take got=%0b exp=0", bus.IFU_pre_take); end
    checks++; if (bus.IFU_pre_target !== 32'h8000_0014) begin failures++; $display("FAIL reset_target got=%h exp=80000014", bus.IFU_pre_target); end
    checks++; if (bus.BHT_correct_cnt !== 32'd0) begin failures++; $display("FAIL reset_correct got=%0d exp=0", bus.BHT_correct_cnt); end
    checks++; if (bus.BHT_wrong_cnt !== 32'd0) begin failures++; $display("FAIL reset_wrong got=%0d exp=0", bus.BHT_wrong_cnt); end
  endtask

  task automatic test_allocate;
    pulse(32'h8000_0010, 1'b0, 1'b1, 32'h8000_0100);
    bus.IFU_pc = 32'h8000_0010; #1;
    checks++; if (bus.IFU_pre_take !== 1'b1) begin failures++; $display("FAIL alloc_take got=%0b exp=1", bus.IFU_pre_take); end
    checks++; if (bus.IFU_pre_target !== 32'h8000_0100) begin failures++; $display("FAIL alloc_target got=%h exp=80000100", bus.IFU_pre_target); end
    checks++; if (bus.BHT_wrong_cnt !== 32'd1) begin failures++; $display("FAIL alloc_wrong got=%0d exp=1", bus.BHT_wrong_cnt); end
  endtask

  // ctr starts at 10: NT,NT,NT -> 01,00,00; T x4 -> 01,10,11,11; NT,NT -> 10,01.
  task automatic test_counter;
    logic [8:0] tk_v   = 9'b001111000;
    logic [8:0] take_v = 9'b011110000;
    for (int i = 0; i < 9; i++) begin
      pulse(32'h8000_0010, i[0], tk_v[i], 32'h8000_0200);
      bus.IFU_pc = 32'h8000_0010; #1;
      checks++;
      if (bus.IFU_pre_take !== take_v[i]) begin
        failures++; $display("FAIL ctr_step%0d_take got=%0b exp=%0b", i, bus.IFU_pre_take, take_v[i]);
      end
      checks++;
      if (bus.IFU_pre_target !== (take_v[i] ? 32'h8000_0200 : 32'h8000_0014)) begin
        failures++; $display("FAIL ctr_step%0d_target got=%h", i, bus.IFU_pre_target);
      end
    end
    checks++; if (bus.BHT_correct_cnt !== exp_ok) begin failures++; $display("FAIL ctr_correct got=%0d exp=%0d", bus.BHT_correct_cnt, exp_ok); end
    checks++; if (bus.BHT_wrong_cnt !== exp_bad) begin failures++; $display("FAIL ctr_wrong got=%0d exp=%0d", bus.BHT_wrong_cnt, exp_bad); end
  endtask

  task automatic test_alias;
    pulse(32'h8000_0050, 1'b1, 1'b1, 32'h8000_0300);
    bus.IFU_pc = 32'h8000_0050; #1;
    checks++; if (bus.IFU_pre_target !== 32'h8000_0300) begin failures++; $display("FAIL alias_new_target got=%h exp=80000300", bus.IFU_pre_target); end
    bus.IFU_pc = 32'h8000_0010; #1;
    checks++; if (bus.IFU_pre_take !== 1'b0) begin failures++; $display("FAIL alias_old_take got=%0b exp=0", bus.IFU_pre_take); end
    pulse(32'h8000_0090, 1'b0, 1'b0, 32'h8000_0400);
    bus.IFU_pc = 32'h8000_0090; #1;
    checks++; if (bus.IFU_pre_target !== 32'h8000_0094) begin failures++; $display("FAIL nt_miss_target got=%h exp=80000094", bus.IFU_pre_target); end
    bus.IFU_pc = 32'h8000_0050; #1;
    checks++; if (bus.IFU_pre_take !== 1'b1) begin failures++; $display("FAIL nt_miss_keep got=%0b exp=1", bus.IFU_pre_take); end
    bus.IFU_pc = 32'h8000_0054; #1;
    checks++; if (bus.IFU_pre_take !== 1'b0) begin failures++; $display("FAIL neighbor_take got=%0b exp=0", bus.IFU_pre_take); end
  endtask

  task automatic test_same_cycle;
    bus.IFU_pc = 32'h8000_0050;
    bus.BHT_pc = 32'h8000_0050; bus.BHT_pre_true = 1'b0; bus.BHT_pre_false = 1'b1;
    bus.BHT_taken = 1'b0; #1;
    checks++; if (bus.IFU_pre_take !== 1'b1) begin failures++; $display("FAIL same_cycle_old got=%0b exp=1", bus.IFU_pre_take); end
    @(posedge clk); #1;
    bus.BHT_pre_false = 1'b0; exp_bad++; #1;
    checks++; if (bus.IFU_pre_take !== 1'b0) begin failures++; $display("FAIL same_cycle_new got=%0b exp=0", bus.IFU_pre_take); end
  endtask

  task automatic test_flush;
    logic [31:0] pcs [3] = '{32'h8000_0020, 32'h8000_0024, 32'h8000_0028};
    @(posedge clk); #1;
    pulse(pcs[0], 1'b1, 1'b1, 32'h8000_0500);
    pulse(pcs[1], 1'b1, 1'b1, 32'h8000_0504);
    bus.IFU_pc = pcs[1]; #1;
    checks++; if (bus.IFU_pre_take !== 1'b1) begin failures++; $display("FAIL preflush_take got=%0b exp=1", bus.IFU_pre_take); end
    bus.BHT_flush = 1'b1;
    pulse(pcs[2], 1'b0, 1'b1, 32'h8000_0508);
    bus.BHT_flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.IFU_pc = pcs[i]; #1;
      checks++;
      if (bus.IFU_pre_target !== pcs[i] + 32'd4) begin
        failures++; $display("FAIL flush_miss%0d got=%h exp=%h", i, bus.IFU_pre_target, pcs[i] + 32'd4);
      end
    end
    checks++; if (bus.BHT_wrong_cnt !== exp_bad) begin failures++; $display("FAIL flush_wrong got=%0d exp=%0d", bus.BHT_wrong_cnt, exp_bad); end
  endtask

  task automatic test_back_to_back_reset;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) pulse(32'h8000_0000 + 32'(4 * i), i[0], 1'b1, 32'h8000_0600);
    bus.BHT_pc = 32'h8000_0010; bus.BHT_pre_true = 1'b1; bus.BHT_taken = 1'b1;
    bus.BHT_target = 32'h8000_0700; bus.BHT_flush = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.BHT_pre_true = 1'b0; bus.BHT_flush = 1'b0;
    exp_ok = '0; exp_bad = '0;
    for (int i = 0; i < 5; i++) begin
      bus.IFU_pc = 32'h8000_0000 + 32'(4 * i); #1;
      checks++;
      if (bus.IFU_pre_take !== 1'b0) begin failures++; $display("FAIL rst_mid_miss%0d got=%0b exp=0", i, bus.IFU_pre_take); end
    end
    checks++; if (bus.BHT_correct_cnt !== 32'd0) begin failures++; $display("FAIL rst_mid_correct got=%0d exp=0", bus.BHT_correct_cnt); end
    checks++; if (bus.BHT_wrong_cnt !== 32'd0) begin failures++; $display("FAIL rst_mid_wrong got=%0d exp=0", bus.BHT_wrong_cnt); end
    pulse(32'h8000_0024, 1'b1, 1'b1, 32'h8000_0800);
    bus.IFU_pc = 32'h8000_0024; #1;
    checks++; if (bus.IFU_pre_target !== 32'h8000_0800) begin failures++; $display("FAIL post_rst_target got=%h exp=80000800", bus.IFU_pre_target); end
    checks++; if (bus.BHT_correct_cnt !== 32'd1) begin failures++; $display("FAIL post_rst_correct got=%0d exp=1", bus.BHT_correct_cnt); end
  endtask

  initial begin
    bus.IFU_pc = '0; bus.BHT_pc = '0; bus.BHT_pre_true = 1'b0; bus.BHT_pre_false = 1'b0;
    bus.BHT_taken = 1'b0; bus.BHT_target = '0; bus.BHT_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_allocate;
    test_counter;
    test_alias;
    test_same_cycle;
    test_flush;
    test_back_to_back_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
